aes_round_sched: RTL and testbench
==================================

# aes_round_sched

Round scheduler for the iterative AES-128 datapath of the AES HWPE engine. It sits between the top-level HWPE FSM and the one-round-per-cycle cipher core plus on-the-fly key-expansion unit. It accepts assembled 128-bit blocks, sequences the initial AddRoundKey, nine full rounds and one final round, and steps the key schedule forward (encrypt) or backward (decrypt). For decrypt jobs it also runs a one-time forward key pre-expansion. It handles a job of N blocks, then reports done.

## Interface
Parameters:
- NB_W, 16, width of the block-count field.

Ports:
- clk  in  1  clock.
- reset_n  in  1  reset, asynchronous, active-low.
- clear  in  1  synchronous clear; same effect as reset.
- start_i  in  1  job start pulse; honoured only in IDLE.
- mode_i  in  1  0 = encrypt, 1 = decrypt; sampled on start.
- num_blocks_i  in  NB_W  blocks in the job; sampled on start.
- in_valid_i / in_ready_o  in/out  1  input block handshake.
- out_valid_o / out_ready_i  out/in  1  output block handshake.
- dp_load_o  out  1  load the input block into the state register and apply the current round key.
- dp_round_en_o  out  1  execute one round on the state register.
- dp_final_o  out  1  final round; skip (Inv)MixColumns.
- dp_inv_o  out  1  use inverse transforms (registered copy of mode).
- key_load_o  out  1  load the key register from the source selected by key_src_o.
- key_src_o  out  1  0 = cipher key, 1 = saved last-round key.
- key_step_o  out  1  advance the key register one schedule step.
- key_dir_o  out  1  0 = forward step, 1 = reverse step.
- key_save_o  out  1  copy the key register into the saved-last-key register.
- rcon_o  out  8  Rcon byte for the current step.
- round_o  out  4  current round index, 0..10.
- busy_o  out  1  high in every state except IDLE.
- done_o  out  1  one-cycle pulse at job end.
- blocks_done_o  out  NB_W  blocks output in the current job.

## Operation
- States: IDLE, KEYEXP, KSAVE, WAIT_IN, ROUND, OUT, FINISH.
- IDLE
  - On start_i: capture mode_i and num_blocks_i, and assert key_load_o with key_src_o=0 in the same cycle.
  - If num_blocks_i==0, go to FINISH.
  - Otherwise go to KEYEXP if decrypting, or WAIT_IN if encrypting.
- KEYEXP (decrypt only, once per job)
  - Runs 10 cycles, steps k=1..10.
  - Each cycle: key_step_o=1, key_dir_o=0, rcon_o=RCON[k].
  - Then go to KSAVE.
- KSAVE: 1 cycle, key_save_o=1, then WAIT_IN.
- WAIT_IN
  - in_ready_o=1.
  - On the handshake cycle (combinational on in_valid_i): dp_load_o=1 and key_step_o=1.
    - Encrypt: forward step, RCON[1].
    - Decrypt: reverse step, RCON[10].
  - round_o=0; then go to ROUND with round=1.
- ROUND, r = 1..10
  - dp_round_en_o=1; round_o=r.
  - For r≤9: key_step_o=1.
    - Encrypt: forward, RCON[r+1].
    - Decrypt: reverse, RCON[10−r].
  - For r=10: dp_final_o=1, no key step; then go to OUT.
- OUT
  - out_valid_o=1, held until out_ready_i.
  - On the handshake: key_load_o=1 with key_src_o=mode, and blocks_done_o increments.
  - If blocks_done_o+1==num_blocks, go to FINISH; otherwise go to WAIT_IN.
- FINISH: done_o=1 for 1 cycle, then IDLE.
- RCON[1..10] = 01,02,04,08,10,20,40,80,1B,36. rcon_o=00 whenever key_step_o=0.
- start_i outside IDLE is ignored. mode_i and num_blocks_i changes after start are ignored.
- blocks_done_o is cleared on the start_i handshake in IDLE. It holds its value after FINISH until the next start or clear.
- A reset or clear mid-job (any state) aborts the job: the block goes to IDLE, all outputs return to reset values, and no done_o is generated.

## Timing
- Reset and clear values:
  - All outputs are 0 and state is IDLE.
  - The exceptions are dp_inv_o and the control outputs, which are also 0; there are no non-zero reset values.
- Input handshake in cycle c → ROUND cycles c+1..c+10 → out_valid_o first high in cycle c+11.
- Block-to-block throughput with out_ready_i=1 and in_valid_i=1: 12 cycles per block (1 WAIT_IN + 10 ROUND + 1 OUT).
- Decrypt job overhead: 11 cycles (10 KEYEXP + 1 KSAVE) before in_ready_o first rises.
- start_i in cycle s:
  - Encrypt: in_ready_o is high in s+1.
  - num_blocks_i==0: done_o is high in s+1.
- out_valid_o is stable under backpressure. Outputs change only at out_ready_i handshakes or on clear.

## Test plan
- Encrypt, 1 block, with the datapath model: key 000102…0f, plaintext 00112233…eeff → ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a. out_valid_o rises exactly 11 cycles after the input handshake, and the rcon_o trace is 01..36 ending at r=9.
- Decrypt of the same ciphertext → plaintext 00112233…eeff.
  - busy_o is high for 10 KEYEXP cycles and key_save_o pulses once.
  - The reverse rcon_o trace is 36,1B,80,…,01.
- num_blocks=3 encrypt with out_ready_i held low 5 cycles per block → three correct ciphertexts. key_load_o src=0 fires after each output, blocks_done_o reads 3, and done_o is a single pulse.
- num_blocks=0 → done_o high in the cycle after start, with no in_ready_o, key_step_o or dp_* activity.
- clear asserted at ROUND r=5 → next cycle IDLE with busy_o=0, round_o=0 and blocks_done_o=0. No done_o is generated, and a following job completes correctly.
- start_i pulsed during ROUND and OUT → ignored. Job results, mode and blocks_done_o are unchanged.

Source files
------------

// File: rtl/aes_round_sched_if.sv
// rtl/aes_round_sched_if.sv - block in/out handshake bundle for the AES round scheduler
interface aes_round_sched_if;
    logic in_valid_i;
    logic in_ready_o;
    logic out_valid_o;
    logic out_ready_i;

    modport slave (
        input  in_valid_i,
        input  out_ready_i,
        output in_ready_o,
        output out_valid_o
    );

    modport master (
        output in_valid_i,
        output out_ready_i,
        input  in_ready_o,
        input  out_valid_o
    );
endinterface

// File: rtl/aes_round_sched.sv
// rtl/aes_round_sched.sv - AES-128 round/key-schedule sequencer for the iterative cipher core
module aes_round_sched #(
    parameter int NB_W = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clear,
    input  logic              start_i,
    input  logic              mode_i,
    input  logic [NB_W-1:0]   num_blocks_i,
    aes_round_sched_if.slave  hs,
    output logic              dp_load_o,
    output logic              dp_round_en_o,
    output logic              dp_final_o,
    output logic              dp_inv_o,
    output logic              key_load_o,
    output logic              key_src_o,
    output logic              key_step_o,
    output logic              key_dir_o,
    output logic              key_save_o,
    output logic [7:0]        rcon_o,
    output logic [3:0]        round_o,
    output logic              busy_o,
    output logic              done_o,
    output logic [NB_W-1:0]   blocks_done_o
);

    typedef enum logic [2:0] {
        S_IDLE, S_KEYEXP, S_KSAVE, S_WAIT_IN, S_ROUND, S_OUT, S_FINISH
    } state_t;

    state_t            state_q, state_d;
    logic              mode_q, mode_d;
    logic [NB_W-1:0]   num_q, num_d;
    logic [NB_W-1:0]   bdone_q, bdone_d;
    logic [NB_W-1:0]   bdone_inc;
    logic [3:0]        round_q, round_d;
    logic [3:0]        kcnt_q, kcnt_d;
    logic [3:0]        rcon_idx;

    // Index 0 means "no key step" and yields a zero Rcon byte.
    function automatic logic [7:0] rcon_f(input logic [3:0] k);
        case (k)
            4'd1:    rcon_f = 8'h01;
            4'd2:    rcon_f = 8'h02;
            4'd3:    rcon_f = 8'h04;
            4'd4:    rcon_f = 8'h08;
            4'd5:    rcon_f = 8'h10;
            4'd6:    rcon_f = 8'h20;
            4'd7:    rcon_f = 8'h40;
            4'd8:    rcon_f = 8'h80;
            4'd9:    rcon_f = 8'h1b;
            4'd10:   rcon_f = 8'h36;
            default: rcon_f = 8'h00;
        endcase
    endfunction

    assign bdone_inc     = bdone_q + {{(NB_W-1){1'b0}}, 1'b1};
    assign rcon_o        = rcon_f(rcon_idx);
    assign round_o       = round_q;
    assign busy_o        = (state_q != S_IDLE);
    assign dp_inv_o      = mode_q;
    assign blocks_done_o = bdone_q;

    // Next-state and per-cycle datapath/key-schedule controls.
    always_comb begin
        state_d       = state_q;
        mode_d        = mode_q;
        num_d         = num_q;
        bdone_d       = bdone_q;
        round_d       = round_q;
        kcnt_d        = kcnt_q;
        rcon_idx      = 4'd0;
        hs.in_ready_o  = 1'b0;
        hs.out_valid_o = 1'b0;
        dp_load_o     = 1'b0;
        dp_round_en_o = 1'b0;
        dp_final_o    = 1'b0;
        key_load_o    = 1'b0;
        key_src_o     = 1'b0;
        key_step_o    = 1'b0;
        key_dir_o     = 1'b0;
        key_save_o    = 1'b0;
        done_o        = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    mode_d     = mode_i;
                    num_d      = num_blocks_i;
                    bdone_d    = '0;
                    kcnt_d     = 4'd1;
                    key_load_o = 1'b1;
                    if (num_blocks_i == '0) state_d = S_FINISH;
                    else if (mode_i)        state_d = S_KEYEXP;
                    else                    state_d = S_WAIT_IN;
                end
            end
            S_KEYEXP: begin
                // Forward-expand to the last round key so decryption can walk backwards.
                key_step_o = 1'b1;
                rcon_idx   = kcnt_q;
                kcnt_d     = kcnt_q + 4'd1;
                if (kcnt_q == 4'd10) state_d = S_KSAVE;
            end
            S_KSAVE: begin
                key_save_o = 1'b1;
                state_d    = S_WAIT_IN;
            end
            S_WAIT_IN: begin
                hs.in_ready_o = 1'b1;
                if (hs.in_valid_i) begin
                    dp_load_o  = 1'b1;
                    key_step_o = 1'b1;
                    key_dir_o  = mode_q;
                    rcon_idx   = mode_q ? 4'd10 : 4'd1;
                    round_d    = 4'd1;
                    state_d    = S_ROUND;
                end
            end
            S_ROUND: begin
                dp_round_en_o = 1'b1;
                if (round_q == 4'd10) begin
                    dp_final_o = 1'b1;
                    round_d    = 4'd0;
                    state_d    = S_OUT;
                end else begin
                    key_step_o = 1'b1;
                    key_dir_o  = mode_q;
                    rcon_idx   = mode_q ? (4'd10 - round_q) : (round_q + 4'd1);
                    round_d    = round_q + 4'd1;
                end
            end
            S_OUT: begin
                hs.out_valid_o = 1'b1;
                if (hs.out_ready_i) begin
                    // Rewind the key register to the starting key of the next block.
                    key_load_o = 1'b1;
                    key_src_o  = mode_q;
                    bdone_d    = bdone_inc;
                    state_d    = (bdone_inc == num_q) ? S_FINISH : S_WAIT_IN;
                end
            end
            S_FINISH: begin
                done_o  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (clear) begin
            state_d = S_IDLE;
            mode_d  = 1'b0;
            num_d   = '0;
            bdone_d = '0;
            round_d = 4'd0;
            kcnt_d  = 4'd0;
        end
    end

    // State and job-context registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            mode_q  <= 1'b0;
            num_q   <= '0;
            bdone_q <= '0;
            round_q <= 4'd0;
            kcnt_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            num_q   <= num_d;
            bdone_q <= bdone_d;
            round_q <= round_d;
            kcnt_q  <= kcnt_d;
        end
    end

endmodule

// File: tb/tb_aes_round_sched.sv
// tb/tb_aes_round_sched.sv - directed bench for aes_round_sched with an AES-128 datapath model
module tb_aes_round_sched;

    logic         clk = 1'b0;
    logic         reset_n, clear, start_i, mode_i;
    logic [15:0]  num_blocks_i;
    logic         dp_load_o, dp_round_en_o, dp_final_o, dp_inv_o;
    logic         key_load_o, key_src_o, key_step_o, key_dir_o, key_save_o;
    logic [7:0]   rcon_o;
    logic [3:0]   round_o;
    logic         busy_o, done_o;
    logic [15:0]  blocks_done_o;

    aes_round_sched_if ifc ();

    aes_round_sched #(.NB_W(16)) dut (
        .clk(clk), .reset_n(reset_n), .clear(clear), .start_i(start_i), .mode_i(mode_i),
        .num_blocks_i(num_blocks_i), .hs(ifc.slave),
        .dp_load_o(dp_load_o), .dp_round_en_o(dp_round_en_o), .dp_final_o(dp_final_o),
        .dp_inv_o(dp_inv_o), .key_load_o(key_load_o), .key_src_o(key_src_o),
        .key_step_o(key_step_o), .key_dir_o(key_dir_o), .key_save_o(key_save_o),
        .rcon_o(rcon_o), .round_o(round_o), .busy_o(busy_o), .done_o(done_o),
        .blocks_done_o(blocks_done_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    localparam logic [127:0] K1  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] P1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] K2  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] P2A = 128'h6bc1bee22e409f96e93d7e117393172a;
    localparam logic [127:0] C2A = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
    localparam logic [127:0] P2B = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
    localparam logic [127:0] C2B = 128'hf5d3d58503b9699de785895a96fdbaaf;
    localparam logic [127:0] P2C = 128'h30c81c46a35ce411e5fbc1191a0a52ef;
    localparam logic [127:0] C2C = 128'h43b1cd7f598ece23881b00e3ed030688;

    logic [7:0]   rc_tab [10];
    logic [7:0]   sbox_t [256];
    logic [7:0]   inv_t  [256];

    // AES reference helpers for the datapath model
    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = xt(x);
        end
        return p;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
    endfunction

    function automatic logic [127:0] fwd_key(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] n0, n1, n2, n3;
        n0 = k[127:96] ^ sub_word({k[23:0], k[31:24]}) ^ {rc, 24'h0};
        n1 = k[95:64] ^ n0;
        n2 = k[63:32] ^ n1;
        n3 = k[31:0]  ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    function automatic logic [127:0] rev_key(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3;
        w3 = k[31:0]  ^ k[63:32];
        w2 = k[63:32] ^ k[95:64];
        w1 = k[95:64] ^ k[127:96];
        w0 = k[127:96] ^ sub_word({w3[23:0], w3[31:24]}) ^ {rc, 24'h0};
        return {w0, w1, w2, w3};
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s, input bit inv);
        logic [127:0] o;
        for (int i = 0; i < 16; i++)
            o[127-8*i -: 8] = inv ? inv_t[s[127-8*i -: 8]] : sbox_t[s[127-8*i -: 8]];
        return o;
    endfunction

    function automatic logic [127:0] shift_rows(input logic [127:0] s, input bit inv);
        logic [127:0] o;
        int src;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) begin
                src = inv ? 4 * ((c - r + 4) % 4) + r : 4 * ((c + r) % 4) + r;
                o[127-8*(4*c+r) -: 8] = s[127-8*src -: 8];
            end
        return o;
    endfunction

    function automatic logic [127:0] mix_cols(input logic [127:0] s, input bit inv);
        logic [127:0] o;
        logic [7:0]   cf [4];
        logic [7:0]   col [4];
        logic [7:0]   acc;
        if (inv) begin cf[0] = 8'h0e; cf[1] = 8'h0b; cf[2] = 8'h0d; cf[3] = 8'h09; end
        else     begin cf[0] = 8'h02; cf[1] = 8'h03; cf[2] = 8'h01; cf[3] = 8'h01; end
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) col[r] = s[127-8*(4*c+r) -: 8];
            for (int r = 0; r < 4; r++) begin
                acc = 8'h00;
                for (int j = 0; j < 4; j++) acc ^= gm(col[j], cf[(j - r + 4) % 4]);
                o[127-8*(4*c+r) -: 8] = acc;
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] enc_round(input logic [127:0] s, input logic [127:0] k, input logic fin);
        logic [127:0] t;
        t = shift_rows(sub_bytes(s, 1'b0), 1'b0);
        if (!fin) t = mix_cols(t, 1'b0);
        return t ^ k;
    endfunction

    function automatic logic [127:0] dec_round(input logic [127:0] s, input logic [127:0] k, input logic fin);
        logic [127:0] t;
        t = sub_bytes(shift_rows(s, 1'b1), 1'b1) ^ k;
        if (!fin) t = mix_cols(t, 1'b1);
        return t;
    endfunction

    // Datapath and key-expansion model driven by the scheduler's control outputs
    logic [127:0] cipher_key = '0;
    logic [127:0] in_block   = '0;
    logic [127:0] m_key = '0, m_saved = '0, m_state = '0;

    always @(posedge clk) begin
        if (key_load_o)      m_key <= key_src_o ? m_saved : cipher_key;
        else if (key_step_o) m_key <= key_dir_o ? rev_key(m_key, rcon_o) : fwd_key(m_key, rcon_o);
        if (key_save_o)      m_saved <= m_key;
        if (dp_load_o)          m_state <= in_block ^ m_key;
        else if (dp_round_en_o) m_state <= dp_inv_o ? dec_round(m_state, m_key, dp_final_o)
                                                    : enc_round(m_state, m_key, dp_final_o);
    end

    // Cycle counter and event log, sampled mid-cycle
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int           hs_q[$], lat_q[$];
    logic [127:0] res_q[$];
    logic [7:0]   rcon_log[$];
    logic [127:0] blk_q[$];
    int  last_hs, ksave_cnt, done_cnt, done_cyc, start_cyc, start_cnt;
    int  in_ready_cnt, first_rdy, busy_pre, act_cnt, kl0, kl1, stall_drop;
    bit  ov_prev = 0, or_prev = 0, timed_out;

    always @(negedge clk) begin
        if (ifc.in_valid_i && ifc.in_ready_o) begin hs_q.push_back(cyc); last_hs = cyc; end
        if (ifc.out_valid_o && !ov_prev) lat_q.push_back(cyc - last_hs);
        if (ov_prev && !or_prev && !ifc.out_valid_o) stall_drop++;
        ov_prev = ifc.out_valid_o;
        or_prev = ifc.out_ready_i;
        if (key_step_o) rcon_log.push_back(rcon_o);
        if (key_save_o) ksave_cnt++;
        if (done_o) begin done_cnt++; done_cyc = cyc; end
        if (start_i && !busy_o) begin start_cyc = cyc; start_cnt++; end
        if (busy_o && !ifc.in_ready_o && first_rdy < 0) busy_pre++;
        if (ifc.in_ready_o) begin in_ready_cnt++; if (first_rdy < 0) first_rdy = cyc; end
        if (key_step_o || dp_load_o || dp_round_en_o || dp_final_o || ifc.out_valid_o) act_cnt++;
        if (ifc.out_valid_o && ifc.out_ready_i) begin
            res_q.push_back(m_state);
            if (key_load_o) begin if (key_src_o) kl1++; else kl0++; end
        end
    end

    task automatic clear_logs();
        hs_q.delete(); lat_q.delete(); res_q.delete(); rcon_log.delete();
        last_hs = 0; ksave_cnt = 0; done_cnt = 0; done_cyc = -100; start_cyc = 0; start_cnt = 0;
        in_ready_cnt = 0; first_rdy = -1; busy_pre = 0; act_cnt = 0; kl0 = 0; kl1 = 0; stall_drop = 0;
    endtask

    task automatic run_job(input bit mode, input int nb, input logic [127:0] key,
                           input int delay, input bit poke);
        int fed = 0;
        int ovc = 0;
        bit poke_now = 0, poked_rnd = 0, poked_out = 0, fin = 0;
        timed_out = 0;
        cipher_key = key;
        @(posedge clk); #1;
        start_i = 1'b1; mode_i = mode; num_blocks_i = 16'(nb);
        ifc.in_valid_i = 1'b0; ifc.out_ready_i = (delay == 0);
        for (int c = 0; c < 1000 && !fin; c++) begin
            @(negedge clk);
            poke_now = 0;
            if (ifc.in_valid_i && ifc.in_ready_o) fed++;
            if (ifc.out_valid_o && ifc.out_ready_i) ovc = 0;
            else if (ifc.out_valid_o) ovc++;
            if (done_o) fin = 1;
            if (poke && round_o == 4'd3 && !poked_rnd) begin poke_now = 1; poked_rnd = 1; end
            if (poke && ifc.out_valid_o && !poked_out) begin poke_now = 1; poked_out = 1; end
            @(posedge clk); #1;
            start_i = poke_now;
            mode_i = poke_now ? ~mode : mode;
            num_blocks_i = poke_now ? 16'd5 : 16'(nb);
            ifc.in_valid_i = (fed < nb);
            if (fed < nb) in_block = blk_q[fed];
            ifc.out_ready_i = (delay == 0) || (ovc >= delay);
        end
        if (!fin) timed_out = 1;
        start_i = 1'b0; ifc.in_valid_i = 1'b0; ifc.out_ready_i = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; clear = 1'b0; start_i = 1'b0; mode_i = 1'b0; num_blocks_i = 16'd0;
        ifc.in_valid_i = 1'b0; ifc.out_ready_i = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy_o, done_o, ifc.in_ready_o, ifc.out_valid_o} !== 4'b0) begin
            errors++; $display("FAIL reset_status got %b exp 0000", {busy_o, done_o, ifc.in_ready_o, ifc.out_valid_o});
        end
        checks++;
        if ({dp_load_o, dp_round_en_o, dp_final_o, dp_inv_o, key_load_o, key_src_o,
             key_step_o, key_dir_o, key_save_o} !== 9'b0) begin
            errors++; $display("FAIL reset_ctrl got %b exp 0", {dp_load_o, dp_round_en_o, dp_final_o,
                dp_inv_o, key_load_o, key_src_o, key_step_o, key_dir_o, key_save_o});
        end
        checks++;
        if ({rcon_o, round_o, blocks_done_o} !== 28'b0) begin
            errors++; $display("FAIL reset_values got rcon %h round %0d blocks %0d exp 0", rcon_o, round_o, blocks_done_o);
        end
        @(posedge clk); #1 reset_n = 1'b1;
    endtask

    task automatic test_encrypt();
        int bad = 0;
        clear_logs();
        blk_q = '{P1};
        run_job(1'b0, 1, K1, 0, 1'b0);
        checks++;
        if (timed_out !== 0) begin errors++; $display("FAIL enc_timeout got %0d exp 0", timed_out); end
        checks++;
        if (res_q.size() != 1 || res_q[0] !== C1) begin
            errors++; $display("FAIL enc_cipher got %h exp %h", res_q.size() ? res_q[0] : 128'bx, C1);
        end
        checks++;
        if (lat_q.size() != 1 || lat_q[0] != 11) begin
            errors++; $display("FAIL enc_latency got %0d exp 11", lat_q.size() ? lat_q[0] : -1);
        end
        checks++;
        if (first_rdy - start_cyc != 1) begin
            errors++; $display("FAIL enc_ready_delay got %0d exp 1", first_rdy - start_cyc);
        end
        if (rcon_log.size() != 10) bad++;
        else for (int i = 0; i < 10; i++) if (rcon_log[i] !== rc_tab[i]) bad++;
        checks++;
        if (bad != 0) begin errors++; $display("FAIL enc_rcon_trace got %0d bad of %0d exp 0 bad of 10", bad, rcon_log.size()); end
        checks++;
        if (done_cnt != 1 || blocks_done_o !== 16'd1) begin
            errors++; $display("FAIL enc_done got done %0d blocks %0d exp 1 1", done_cnt, blocks_done_o);
        end
    endtask

    task automatic test_decrypt();
        int bad = 0;
        clear_logs();
        blk_q = '{C1};
        run_job(1'b1, 1, K1, 0, 1'b0);
        checks++;
        if (timed_out !== 0 || res_q.size() != 1 || res_q[0] !== P1) begin
            errors++; $display("FAIL dec_plain got %h exp %h", res_q.size() ? res_q[0] : 128'bx, P1);
        end
        checks++;
        if (ksave_cnt != 1) begin errors++; $display("FAIL dec_ksave got %0d exp 1", ksave_cnt); end
        checks++;
        if (busy_pre != 11 || first_rdy - start_cyc != 12) begin
            errors++; $display("FAIL dec_overhead got busy %0d rdy %0d exp 11 12", busy_pre, first_rdy - start_cyc);
        end
        if (rcon_log.size() != 20) bad++;
        else for (int i = 0; i < 10; i++) begin
            if (rcon_log[i] !== rc_tab[i]) bad++;
            if (rcon_log[10+i] !== rc_tab[9-i]) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL dec_rcon_trace got %0d bad of %0d exp 0 bad of 20", bad, rcon_log.size()); end
    endtask

    task automatic test_back_to_back();
        clear_logs();
        blk_q = '{P2A, P2B, P2C};
        run_job(1'b0, 3, K2, 0, 1'b0);
        checks++;
        if (timed_out !== 0 || res_q.size() != 3) begin
            errors++; $display("FAIL b2b_count got %0d exp 3", res_q.size());
        end else if (res_q[0] !== C2A || res_q[1] !== C2B || res_q[2] !== C2C) begin
            errors++; $display("FAIL b2b_cipher got %h %h %h exp %h %h %h", res_q[0], res_q[1], res_q[2], C2A, C2B, C2C);
        end
        checks++;
        if (hs_q.size() != 3 || hs_q[1] - hs_q[0] != 12 || hs_q[2] - hs_q[1] != 12) begin
            errors++; $display("FAIL b2b_throughput got %0d handshakes exp 3 spaced 12", hs_q.size());
        end
    endtask

    task automatic test_backpressure();
        clear_logs();
        blk_q = '{P2A, P2B, P2C};
        run_job(1'b0, 3, K2, 5, 1'b0);
        checks++;
        if (timed_out !== 0 || res_q.size() != 3) begin
            errors++; $display("FAIL bp_count got %0d exp 3", res_q.size());
        end else if (res_q[0] !== C2A || res_q[1] !== C2B || res_q[2] !== C2C) begin
            errors++; $display("FAIL bp_cipher got %h %h %h exp %h %h %h", res_q[0], res_q[1], res_q[2], C2A, C2B, C2C);
        end
        checks++;
        if (kl0 != 3 || kl1 != 0) begin errors++; $display("FAIL bp_keyload got src0 %0d src1 %0d exp 3 0", kl0, kl1); end
        checks++;
        if (blocks_done_o !== 16'd3 || done_cnt != 1) begin
            errors++; $display("FAIL bp_done got blocks %0d done %0d exp 3 1", blocks_done_o, done_cnt);
        end
        checks++;
        if (stall_drop != 0) begin errors++; $display("FAIL bp_valid_stable got %0d drops exp 0", stall_drop); end
    endtask

    task automatic test_zero_blocks();
        clear_logs();
        blk_q.delete();
        run_job(1'b0, 0, K1, 0, 1'b0);
        checks++;
        if (timed_out !== 0 || done_cnt != 1 || done_cyc - start_cyc != 1) begin
            errors++; $display("FAIL zero_done got cnt %0d delay %0d exp 1 1", done_cnt, done_cyc - start_cyc);
        end
        checks++;
        if (in_ready_cnt != 0 || act_cnt != 0) begin
            errors++; $display("FAIL zero_quiet got ready %0d act %0d exp 0 0", in_ready_cnt, act_cnt);
        end
    endtask

    task automatic test_clear_mid();
        bit found = 0;
        clear_logs();
        cipher_key = K1;
        @(posedge clk); #1;
        start_i = 1'b1; mode_i = 1'b0; num_blocks_i = 16'd2;
        @(posedge clk); #1;
        start_i = 1'b0; in_block = P1; ifc.in_valid_i = 1'b1; ifc.out_ready_i = 1'b1;
        for (int c = 0; c < 100 && !found; c++) begin
            @(negedge clk);
            if (blocks_done_o == 16'd1 && round_o == 4'd5) found = 1;
        end
        checks++;
        if (found !== 1) begin errors++; $display("FAIL clr_reach got %0d exp 1", found); end
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0; ifc.in_valid_i = 1'b0; ifc.out_ready_i = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy_o, round_o, blocks_done_o, dp_inv_o, ifc.out_valid_o} !== 23'b0) begin
            errors++; $display("FAIL clr_idle got busy %b round %0d blocks %0d exp 0 0 0", busy_o, round_o, blocks_done_o);
        end
        repeat (5) @(negedge clk);
        checks++;
        if (done_cnt != 0) begin errors++; $display("FAIL clr_no_done got %0d exp 0", done_cnt); end
        clear_logs();
        blk_q = '{P1};
        run_job(1'b0, 1, K1, 0, 1'b0);
        checks++;
        if (timed_out !== 0 || res_q.size() != 1 || res_q[0] !== C1 || done_cnt != 1) begin
            errors++; $display("FAIL clr_next_job got %h done %0d exp %h 1", res_q.size() ? res_q[0] : 128'bx, done_cnt, C1);
        end
    endtask

    task automatic test_start_ignored();
        clear_logs();
        blk_q = '{C2A};
        run_job(1'b1, 1, K2, 3, 1'b1);
        checks++;
        if (timed_out !== 0 || res_q.size() != 1 || res_q[0] !== P2A) begin
            errors++; $display("FAIL ign_plain got %h exp %h", res_q.size() ? res_q[0] : 128'bx, P2A);
        end
        checks++;
        if (dp_inv_o !== 1'b1 || blocks_done_o !== 16'd1 || done_cnt != 1 || start_cnt != 1) begin
            errors++; $display("FAIL ign_state got inv %b blocks %0d done %0d starts %0d exp 1 1 1 1",
                               dp_inv_o, blocks_done_o, done_cnt, start_cnt);
        end
    endtask

    initial begin
        logic [7:0] b, inv;
        rc_tab = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
        for (int i = 0; i < 256; i++) begin
            inv = 8'h00;
            for (int j = 1; j < 256; j++) if (i != 0 && gm(8'(i), 8'(j)) == 8'h01) inv = 8'(j);
            b = inv;
            sbox_t[i] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
        end
        for (int i = 0; i < 256; i++) inv_t[sbox_t[i]] = 8'(i);
        clear_logs();
        test_reset();
        test_encrypt();
        test_decrypt();
        test_back_to_back();
        test_backpressure();
        test_zero_blocks();
        test_clear_mid();
        test_start_ignored();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
